// File: rtl/rpn_pkg.sv
// Shared opcode, FSM-state and operand-need definitions for the RPN stack engine.
// Pure declarations: no latency, no backpressure.
package rpn_pkg;

    localparam logic [2:0] OP_PUSH  = 3'd0;
    localparam logic [2:0] OP_POP   = 3'd1;
    localparam logic [2:0] OP_ADD   = 3'd2;
    localparam logic [2:0] OP_SUB   = 3'd3;
    localparam logic [2:0] OP_MUL   = 3'd4;
    localparam logic [2:0] OP_DUP   = 3'd5;
    localparam logic [2:0] OP_SWAP  = 3'd6;
    localparam logic [2:0] OP_CLEAR = 3'd7;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD1  = 3'd1;
    localparam logic [2:0] S_RD2  = 3'd2;
    localparam logic [2:0] S_EXEC = 3'd3;
    localparam logic [2:0] S_WB   = 3'd4;

    function automatic logic [1:0] op_need(input logic [2:0] op);
        case (op)
            OP_POP, OP_DUP:                  op_need = 2'd1;
            OP_ADD, OP_SUB, OP_MUL, OP_SWAP: op_need = 2'd2;
            default:                         op_need = 2'd0;
        endcase
    endfunction

    function automatic logic op_slot(input logic [2:0] op);
        op_slot = (op == OP_PUSH) || (op == OP_DUP);
    endfunction

endpackage

// File: rtl/rpn_stack_ram.sv
// Operand stack storage: one write port, one synchronous read port.
// Read latency 1 cycle; no backpressure (always accepts).
module rpn_stack_ram #(
    parameter int WIDTH   = 8,
    parameter int DEPTH_W = 4
) (
    input  logic               CLOCK_50,
    input  logic               we,
    input  logic [DEPTH_W-1:0] waddr,
    input  logic [WIDTH-1:0]   wdata,
    input  logic [DEPTH_W-1:0] raddr,
    output logic [WIDTH-1:0]   rdata
);

    logic [WIDTH-1:0] mem [2**DEPTH_W];

    always_ff @(posedge CLOCK_50) begin
        if (we)
            mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/rpn_stack_engine.sv
// RPN operand-stack engine: FSM, stack pointer, ALU; RPN_SATURATE_EN selects clamping arithmetic.
// Accept->done: PUSH/CLEAR 2, POP/DUP 3, binary/SWAP 5, error 1 cycle; cmd_ready only in S_IDLE.
module rpn_stack_engine
    import rpn_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int DEPTH_W = 4
) (
    input  logic               CLOCK_50,
    input  logic               RESET,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [2:0]         cmd_op,
    input  logic [WIDTH-1:0]   cmd_data,
    output logic               done,
    output logic [WIDTH-1:0]   top,
    output logic [DEPTH_W:0]   depth,
    output logic               empty,
    output logic               full,
    output logic               err
);

    localparam logic [DEPTH_W:0] CAP = {1'b1, {DEPTH_W{1'b0}}};

    logic [2:0]         state;
    logic [2:0]         op_q;
    logic [WIDTH-1:0]   dat_q, a_q, b_q, alu_res, rd_data, wdata;
    logic               swap_2nd, we;
    logic [DEPTH_W-1:0] ptr0, ptr1, ptr2, raddr, waddr;

    assign ptr0      = depth[DEPTH_W-1:0];
    assign ptr1      = ptr0 - DEPTH_W'(1);
    assign ptr2      = ptr0 - DEPTH_W'(2);
    assign cmd_ready = (state == S_IDLE);
    assign empty     = (depth == '0);
    assign full      = (depth == CAP);

    rpn_stack_ram #(.WIDTH(WIDTH), .DEPTH_W(DEPTH_W)) u_ram (
        .CLOCK_50 (CLOCK_50),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .raddr    (raddr),
        .rdata    (rd_data)
    );

`ifdef RPN_SATURATE_EN
    logic [WIDTH:0]     sum_w;
    logic [2*WIDTH-1:0] prod_w;
    always_comb begin
        sum_w  = {1'b0, a_q} + {1'b0, b_q};
        prod_w = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
        case (op_q)
            OP_SUB:  alu_res = (a_q < b_q) ? '0 : a_q - b_q;
            OP_MUL:  alu_res = (|prod_w[2*WIDTH-1:WIDTH]) ? '1 : prod_w[WIDTH-1:0];
            default: alu_res = sum_w[WIDTH] ? '1 : sum_w[WIDTH-1:0];
        endcase
    end
`else
    always_comb begin
        case (op_q)
            OP_SUB:  alu_res = a_q - b_q;
            OP_MUL:  alu_res = a_q * b_q;
            default: alu_res = a_q + b_q;
        endcase
    end
`endif

    // POP reads the entry below the top so the new top is ready when depth drops.
    always_comb begin
        raddr = ptr1;
        if (state == S_RD1 && op_q == OP_POP)
            raddr = ptr2;
        else if (state == S_RD2 || state == S_EXEC || state == S_WB)
            raddr = ptr2;
    end

    always_comb begin
        we    = 1'b0;
        waddr = ptr0;
        wdata = dat_q;
        if (state == S_WB) begin
            case (op_q)
                OP_PUSH: we = 1'b1;
                OP_DUP: begin
                    we    = 1'b1;
                    wdata = rd_data;
                end
                OP_ADD, OP_SUB, OP_MUL: begin
                    we    = 1'b1;
                    waddr = ptr2;
                    wdata = alu_res;
                end
                OP_SWAP: begin
                    we    = 1'b1;
                    waddr = swap_2nd ? ptr2 : ptr1;
                    wdata = swap_2nd ? b_q : rd_data;
                end
                default: we = 1'b0;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state    <= S_IDLE;
            depth    <= '0;
            top      <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            op_q     <= OP_PUSH;
            dat_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            swap_2nd <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: if (cmd_valid) begin
                    op_q  <= cmd_op;
                    dat_q <= cmd_data;
                    if ((depth < (DEPTH_W+1)'(op_need(cmd_op))) || (full && op_slot(cmd_op))) begin
                        err  <= 1'b1;
                        done <= 1'b1;
                    end else if (op_need(cmd_op) == 2'd0)
                        state <= S_WB;
                    else
                        state <= S_RD1;
                end
                S_RD1: state <= (op_need(op_q) == 2'd2) ? S_RD2 : S_WB;
                S_RD2: begin
                    b_q   <= rd_data;
                    state <= (op_q == OP_SWAP) ? S_WB : S_EXEC;
                end
                S_EXEC: begin
                    a_q   <= rd_data;
                    state <= S_WB;
                end
                S_WB: begin
                    case (op_q)
                        OP_PUSH: begin
                            depth <= depth + 1'b1;
                            top   <= dat_q;
                        end
                        OP_POP: begin
                            depth <= depth - 1'b1;
                            top   <= (depth == (DEPTH_W+1)'(1)) ? '0 : rd_data;
                        end
                        OP_DUP: begin
                            depth <= depth + 1'b1;
                            top   <= rd_data;
                        end
                        OP_CLEAR: begin
                            depth <= '0;
                            err   <= 1'b0;
                            top   <= '0;
                        end
                        OP_SWAP: if (!swap_2nd) top <= rd_data;
                        default: begin
                            depth <= depth - 1'b1;
                            top   <= alu_res;
                        end
                    endcase
                    if (op_q == OP_SWAP && !swap_2nd)
                        swap_2nd <= 1'b1;
                    else begin
                        swap_2nd <= 1'b0;
                        done     <= 1'b1;
                        state    <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rpn_stack_engine.sv
// Directed self-checking bench for rpn_stack_engine (WIDTH=8, DEPTH_W=4).
module tb_rpn_stack_engine;

    logic       CLOCK_50 = 1'b0;
    logic       RESET = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_op = 3'd0;
    logic [7:0] cmd_data = 8'd0;
    logic       done;
    logic [7:0] top;
    logic [4:0] depth;
    logic       empty, full, err;

    int vectors = 0;
    int miscompares = 0;

    localparam logic [2:0] PUSH = 3'd0, POP = 3'd1, ADD = 3'd2, SUB = 3'd3,
                           MUL = 3'd4, DUP = 3'd5, SWAP = 3'd6, CLEAR = 3'd7;

`ifdef RPN_SATURATE_EN
    localparam int EXP_SUB = 0;
    localparam int EXP_MUL = 255;
`else
    localparam int EXP_SUB = 254;
    localparam int EXP_MUL = 0;
`endif

    always #10 CLOCK_50 = ~CLOCK_50;

    rpn_stack_engine #(.WIDTH(8), .DEPTH_W(4)) dut (
        .CLOCK_50  (CLOCK_50),
        .RESET     (RESET),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .done      (done),
        .top       (top),
        .depth     (depth),
        .empty     (empty),
        .full      (full),
        .err       (err)
    );

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Issues one command and returns the number of cycles until done is seen.
    task automatic run(input string tag, input logic [2:0] op, input logic [7:0] d, input int exp_lat);
        int lat;
        cmd_op    = op;
        cmd_data  = d;
        cmd_valid = 1'b1;
        @(posedge CLOCK_50);
        #1;
        cmd_valid = 1'b0;
        lat = 1;
        while (done !== 1'b1 && lat < 20) begin
            @(posedge CLOCK_50);
            #1;
            lat++;
        end
        chk({tag, "_lat"}, lat, exp_lat);
    endtask

    initial begin
        repeat (2) @(posedge CLOCK_50);
        #1;
        RESET = 1'b0;
        chk("rst_depth", depth, 0);
        chk("rst_top", top, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_ready", cmd_ready, 1);
        chk("rst_empty", empty, 1);

        run("push5", PUSH, 8'd5, 2);
        run("push3", PUSH, 8'd3, 2);
        run("add", ADD, 8'd0, 5);
        chk("add_top", top, 8);
        chk("add_depth", depth, 1);
        chk("add_err", err, 0);

        run("clr1", CLEAR, 8'd0, 2);
        run("p3", PUSH, 8'd3, 2);
        run("p5", PUSH, 8'd5, 2);
        run("sub", SUB, 8'd0, 5);
        chk("sub_top", top, EXP_SUB);
        chk("sub_depth", depth, 1);
        run("p16a", PUSH, 8'd16, 2);
        run("p16b", PUSH, 8'd16, 2);
        run("mul", MUL, 8'd0, 5);
        chk("mul_top", top, EXP_MUL);
        chk("mul_depth", depth, 2);
        chk("mul_err", err, 0);

        run("clr2", CLEAR, 8'd0, 2);
        run("add_under", ADD, 8'd0, 1);
        chk("under_err", err, 1);
        chk("under_depth", depth, 0);
        run("clr3", CLEAR, 8'd0, 2);
        chk("clr_err", err, 0);

        for (int i = 0; i < 16; i++) begin
            run("fill", PUSH, 8'(10 + i), 2);
            if (i == 14) chk("full_at15", full, 0);
        end
        chk("full_at16", full, 1);
        chk("full_top", top, 25);
        run("push_over", PUSH, 8'd99, 1);
        chk("over_err", err, 1);
        chk("over_depth", depth, 16);
        chk("over_top", top, 25);
        run("pop_full", POP, 8'd0, 3);
        chk("pop_full_top", top, 24);
        chk("pop_full_full", full, 0);

        run("clr4", CLEAR, 8'd0, 2);
        run("s_p2", PUSH, 8'd2, 2);
        run("s_p1", PUSH, 8'd1, 2);
        run("swap", SWAP, 8'd0, 5);
        chk("swap_top", top, 2);
        chk("swap_depth", depth, 2);
        run("s_pop", POP, 8'd0, 3);
        chk("pop_top", top, 1);
        run("dup", DUP, 8'd0, 3);
        chk("dup_depth", depth, 2);
        chk("dup_top", top, 1);
        run("pop_a", POP, 8'd0, 3);
        run("pop_b", POP, 8'd0, 3);
        chk("drain_top", top, 0);
        chk("drain_empty", empty, 1);
        run("pop_under", POP, 8'd0, 1);
        chk("pop_under_err", err, 1);
        run("clr5", CLEAR, 8'd0, 2);

        run("r_p7", PUSH, 8'd7, 2);
        run("r_p9", PUSH, 8'd9, 2);
        cmd_op    = ADD;
        cmd_valid = 1'b1;
        @(posedge CLOCK_50);
        #1;
        cmd_valid = 1'b0;
        chk("abort_busy", cmd_ready, 0);
        @(posedge CLOCK_50);
        #1;
        RESET = 1'b1;
        @(posedge CLOCK_50);
        #1;
        RESET = 1'b0;
        chk("abort_done", done, 0);
        chk("abort_depth", depth, 0);
        chk("abort_top", top, 0);
        chk("abort_ready", cmd_ready, 1);
        repeat (4) begin
            @(posedge CLOCK_50);
            #1;
            chk("abort_no_done", done, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
